// File: rtl/exp_sweep_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// exp_sweep_driver : walks every bfloat16 code through the exp unit handshake
//                    and queues {input, result} pairs in a small FWFT FIFO.
// Revision 1.0
// ============================================================================
module exp_sweep_driver #(
  parameter int DW          = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int INCLUDE_NAN = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_timeout_o,
  output logic [16:0]     pair_count_o,
  input  logic            exp_ready_i,
  output logic            exp_valid_o,
  output logic [DW-1:0]   exp_data_o,
  input  logic            exp_valid_i,
  input  logic [DW-1:0]   exp_data_i,
  output logic            exp_padv_o,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [2*DW-1:0] res_data_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int MW = DW - 9;

  // Sign / 8-bit exponent / mantissa layout; infinities bound the NaN-free sweep.
  localparam logic [DW-1:0] NEG_ZERO   = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] NEG_INF    = {1'b1, 8'hFF, {MW{1'b0}}};
  localparam logic [DW-1:0] POS_INF    = {1'b0, 8'hFF, {MW{1'b0}}};
  localparam logic [DW-1:0] START_CODE = (INCLUDE_NAN != 0) ? {DW{1'b1}} : NEG_INF;
  localparam logic [DW-1:0] LAST_CODE  = (INCLUDE_NAN != 0) ? {1'b0, {(DW-1){1'b1}}} : POS_INF;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [DW-1:0]   code;
  logic [DW-1:0]   code_nxt;
  logic [TW-1:0]   tcnt;
  logic [16:0]     pair_count;
  logic [2*DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            start_ok;
  logic            issue;
  logic            push;
  logic            pop;
  logic            timeout_hit;
  logic            last_code;

  assign fifo_full   = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_count == '0);
  assign start_ok    = start_i & ~abort_i &
                       ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  assign issue       = (state == S_ISSUE) & exp_ready_i & ~fifo_full & ~abort_i;
  assign push        = (state == S_WAIT) & exp_valid_i & ~abort_i;
  assign pop         = ~fifo_empty & res_ready_i;
  assign timeout_hit = (state == S_WAIT) & ~exp_valid_i & (tcnt >= TW'(TIMEOUT_CYC - 1));
  assign last_code   = (code == LAST_CODE);

  // Negative half counts down toward -0, then jumps to +0 and counts up.
  always_comb begin
    code_nxt = code + 1'b1;
    if (code == NEG_ZERO)
      code_nxt = '0;
    else if (code[DW-1])
      code_nxt = code - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (start_i) state_nxt = S_ISSUE;
        S_ISSUE:               if (issue) state_nxt = S_WAIT;
        S_WAIT: begin
          if (exp_valid_i)
            state_nxt = S_ACK;
          else if (timeout_hit)
            state_nxt = S_ERR;
        end
        S_ACK:                 state_nxt = last_code ? S_DONE : S_ISSUE;
        default:               state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o        = 1'b0;
    done_o        = 1'b0;
    err_timeout_o = 1'b0;
    exp_valid_o   = 1'b0;
    exp_data_o    = '0;
    exp_padv_o    = 1'b0;
    case (state)
      S_ISSUE: begin
        busy_o      = 1'b1;
        exp_valid_o = exp_ready_i & ~fifo_full;
        exp_data_o  = code;
      end
      S_WAIT: begin
        busy_o     = 1'b1;
        exp_data_o = code;
      end
      S_ACK: begin
        busy_o     = 1'b1;
        exp_padv_o = 1'b1;
      end
      S_DONE:  done_o        = 1'b1;
      S_ERR:   err_timeout_o = 1'b1;
      default: ;
    endcase
  end

  // Timeout counter includes the issue cycle, so ERR lands TIMEOUT_CYC cycles after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code       <= START_CODE;
      tcnt       <= '0;
      pair_count <= '0;
    end else if (start_ok) begin
      code       <= START_CODE;
      tcnt       <= '0;
      pair_count <= '0;
    end else begin
      if (issue)
        tcnt <= TW'(1);
      else if ((state == S_WAIT) && (tcnt != '1))
        tcnt <= tcnt + 1'b1;
      if (push && (pair_count != '1))
        pair_count <= pair_count + 1'b1;
      if ((state == S_ACK) && !abort_i && !last_code)
        code <= code_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {code, exp_data_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign pair_count_o = pair_count;
  assign res_valid_o  = ~fifo_empty;
  assign res_data_o   = mem[rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_exp_sweep_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_exp_sweep_driver : directed bench with behavioural exp-unit stand-ins.
// Revision 1.0
// ============================================================================
module tb_exp_sweep_driver;

  localparam logic [15:0] KEY  = 16'h5A5A;
  localparam logic [9:0]  SKEY = 10'h2A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (bfloat16)
  logic        start, abort, busy, done, err, m_ready, m_vo, m_vi, m_padv;
  logic        res_valid, res_ready, respond;
  logic [16:0] pc;
  logic [15:0] m_do, m_di;
  logic [31:0] res_data;

  // reduced-width instances (10-bit codes) used for full-sweep checks
  logic        s_start, s_ready;
  logic        s0_busy, s0_done, s0_err, s0_vo, s0_vi, s0_padv, s0_rv;
  logic        s1_busy, s1_done, s1_err, s1_vo, s1_vi, s1_padv, s1_rv;
  logic [16:0] s0_pc, s1_pc;
  logic [9:0]  s0_do, s0_di, s1_do, s1_di;
  logic [19:0] s0_rd, s1_rd;

  int n_cmp = 0;
  int n_bad = 0;
  int issues = 0;
  logic [31:0] popq [$];
  logic [31:0] sq0 [$];
  logic [31:0] sq1 [$];

  exp_sweep_driver dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .err_timeout_o(err), .pair_count_o(pc),
    .exp_ready_i(m_ready), .exp_valid_o(m_vo), .exp_data_o(m_do),
    .exp_valid_i(m_vi), .exp_data_i(m_di), .exp_padv_o(m_padv),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data)
  );

  exp_sweep_driver #(.DW(10), .INCLUDE_NAN(0)) dut_s0 (
    .clk(clk), .rst(rst), .start_i(s_start), .abort_i(1'b0),
    .busy_o(s0_busy), .done_o(s0_done), .err_timeout_o(s0_err), .pair_count_o(s0_pc),
    .exp_ready_i(s_ready), .exp_valid_o(s0_vo), .exp_data_o(s0_do),
    .exp_valid_i(s0_vi), .exp_data_i(s0_di), .exp_padv_o(s0_padv),
    .res_valid_o(s0_rv), .res_ready_i(s_ready), .res_data_o(s0_rd)
  );

  exp_sweep_driver #(.DW(10), .INCLUDE_NAN(1)) dut_s1 (
    .clk(clk), .rst(rst), .start_i(s_start), .abort_i(1'b0),
    .busy_o(s1_busy), .done_o(s1_done), .err_timeout_o(s1_err), .pair_count_o(s1_pc),
    .exp_ready_i(s_ready), .exp_valid_o(s1_vo), .exp_data_o(s1_do),
    .exp_valid_i(s1_vi), .exp_data_i(s1_di), .exp_padv_o(s1_padv),
    .res_valid_o(s1_rv), .res_ready_i(s_ready), .res_data_o(s1_rd)
  );

  // Main exp stand-in: 3-cycle latency, result held until padv.
  logic        pend;
  logic [1:0]  mcnt;
  logic [15:0] pdat;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0; m_vi <= 1'b0; m_di <= '0; mcnt <= '0; pdat <= '0;
    end else begin
      if (m_padv) m_vi <= 1'b0;
      if (pend) begin
        if (mcnt == 2'd0) begin
          pend <= 1'b0;
          if (respond) begin
            m_vi <= 1'b1;
            m_di <= pdat ^ KEY;
          end
        end else begin
          mcnt <= mcnt - 2'd1;
        end
      end
      if (m_vo && m_ready) begin
        pend <= 1'b1; pdat <= m_do; mcnt <= 2'd2;
      end
      if (abort) begin
        pend <= 1'b0; m_vi <= 1'b0;
      end
    end
  end

  // Small stand-ins answer one cycle after issue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_vi <= 1'b0; s0_di <= '0; s1_vi <= 1'b0; s1_di <= '0;
    end else begin
      s0_vi <= s0_vo; s0_di <= s0_do ^ SKEY;
      s1_vi <= s1_vo; s1_di <= s1_do ^ SKEY;
    end
  end

  always @(negedge clk) begin
    if (res_valid && res_ready) popq.push_back(res_data);
    if (s0_rv && s_ready) sq0.push_back({12'h000, s0_rd});
    if (s1_rv && s_ready) sq1.push_back({12'h000, s1_rd});
    if (m_vo && m_ready) issues++;
  end

  function automatic logic [31:0] mp(input logic [15:0] c);
    return {c, c ^ KEY};
  endfunction

  function automatic logic [31:0] sp(input logic [9:0] c);
    return {12'h000, c, c ^ SKEY};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    int k;
    int base;
    int base_iss;
    start = 0; abort = 0; res_ready = 0; respond = 1; m_ready = 1;
    s_start = 0; s_ready = 1;
    tick(); tick();
    check("rst_flags", {busy, done, err, m_vo, m_padv, res_valid}, 0);
    check("rst_count", pc, 0);
    check("rst_data", m_do, 0);
    check("rst_res", res_data, 0);
    rst = 0;
    tick();

    // normal sweep start, small instances run the complete sweep in parallel
    res_ready = 1; start = 1; s_start = 1;
    tick();
    start = 0; s_start = 0;
    check("t1_busy", busy, 1);
    for (k = 0; k < 200 && popq.size() < 3; k++) tick();
    check("t1_pop3", popq.size() >= 3, 1);
    check("t1_pair0", popq[0], mp(16'hFF80));
    check("t1_pair1", popq[1], mp(16'hFF7F));
    check("t1_pair2", popq[2], mp(16'hFF7E));
    abort = 1;
    tick();
    abort = 0;
    check("t1_abort_idle", {busy, m_vo, m_padv}, 0);

    for (k = 0; k < 6000 && !(s0_done && s1_done); k++) tick();
    check("s_done", {s0_done, s1_done}, 2'b11);
    check("s_flags", {s0_busy, s0_err, s0_padv, s0_vo, s0_rv, s1_busy, s1_err, s1_padv, s1_vo, s1_rv}, 0);
    check("s0_count", s0_pc, 1022);
    check("s0_popped", sq0.size(), 1022);
    check("s0_first", sq0[0], sp(10'h3FE));
    check("s0_negzero", sq0[510], sp(10'h200));
    check("s0_wrap", sq0[511], sp(10'h000));
    check("s0_last", sq0[sq0.size()-1], sp(10'h1FE));
    check("s1_count", s1_pc, 1024);
    check("s1_popped", sq1.size(), 1024);
    check("s1_first", sq1[0], sp(10'h3FF));
    check("s1_wrap", sq1[512], sp(10'h000));
    check("s1_last", sq1[sq1.size()-1], sp(10'h1FF));

    // back-pressure: consumer stalled from the start
    res_ready = 0;
    base = popq.size();
    base_iss = issues;
    start = 1;
    tick();
    start = 0;
    repeat (100) tick();
    check("t2_count4", pc, 4);
    check("t2_issues4", issues - base_iss, 4);
    check("t2_stall", {m_vo, busy, res_valid}, 3'b011);
    check("t2_head", res_data, mp(16'hFF80));
    res_ready = 1;
    tick();
    res_ready = 0;
    repeat (30) tick();
    check("t2_issues5", issues - base_iss, 5);
    check("t2_count5", pc, 5);
    check("t2_pop1", popq.size() - base, 1);
    check("t2_popval", popq[base], mp(16'hFF80));
    abort = 1; res_ready = 1;
    tick();
    abort = 0;
    repeat (10) tick();
    check("t2_kept", popq.size() - base, 5);
    check("t2_kept_first", popq[base+1], mp(16'hFF7F));
    check("t2_kept_last", popq[base+4], mp(16'hFF7C));

    // timeout: unit never answers
    respond = 0;
    start = 1;
    tick();
    start = 0;
    for (k = 0; k < 20 && !m_vo; k++) tick();
    check("t3_issue", m_vo, 1);
    for (k = 0; k < 200 && !err; k++) tick();
    check("t3_latency", k, 64);
    check("t3_state", {err, busy, done, res_valid}, 4'b1000);
    check("t3_count", pc, 0);

    // abort coincident with the third result
    respond = 1;
    base = popq.size();
    start = 1;
    tick();
    start = 0;
    for (k = 0; k < 100 && pc < 2; k++) tick();
    check("t6_two", pc, 2);
    tick();
    for (k = 0; k < 20 && !m_vi; k++) tick();
    check("t6_valid", m_vi, 1);
    abort = 1;
    tick();
    abort = 0;
    check("t6_idle", {busy, done, err, m_vo, m_padv}, 0);
    check("t6_count", pc, 2);
    repeat (5) tick();
    check("t6_nopush", popq.size() - base, 2);
    check("t6_lastpop", popq[popq.size()-1], mp(16'hFF7F));

    // asynchronous reset in the middle of a WAIT
    start = 1;
    tick();
    start = 0;
    for (k = 0; k < 1000 && pc < 100; k++) tick();
    res_ready = 0;
    for (k = 0; k < 50 && pc < 102; k++) tick();
    for (k = 0; k < 20 && !m_vo; k++) tick();
    tick();
    check("t4_pre", {busy, res_valid, m_vo}, 3'b110);
    #1 rst = 1;
    #1;
    check("t4_flags", {busy, done, err, m_vo, m_padv, res_valid}, 0);
    check("t4_count", pc, 0);
    check("t4_data", m_do, 0);
    tick();
    rst = 0;
    tick();
    base = popq.size();
    res_ready = 1; start = 1;
    tick();
    start = 0;
    for (k = 0; k < 50 && popq.size() <= base; k++) tick();
    check("t4_restart", popq[base], mp(16'hFF80));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
